// File: rtl/serial_word_deserializer.sv
// Assembles WIDTH-bit words from a strobed serial bit stream and hands them off over valid/ready.
// Optional even-parity checking is enabled by defining PARITY_CHECK_EN.
module serial_word_deserializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                           Clock,
  input  logic                           Reset,
  input  logic                           Bit_in,
  input  logic                           Bit_valid,
  input  logic                           Ready,
  output logic [WIDTH-1:0]               Data_out,
  output logic                           Valid_out,
  output logic [$clog2(WIDTH+1)-1:0]     Bit_count,
  output logic                           Overrun,
  output logic                           Parity_err
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

`ifdef PARITY_CHECK_EN
  typedef enum logic [0:0] {StCollect, StParity} state_e;
`else
  typedef enum logic [0:0] {StCollect} state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic [WIDTH-1:0] shift_in;
  logic [WIDTH-1:0] word;
  logic             complete;
`ifdef PARITY_CHECK_EN
  logic             perr_q, perr_d;
  logic             word_perr;
`endif

  always_comb begin
    if (MSB_FIRST) shift_in = {shift_q[WIDTH-2:0], Bit_in};
    else           shift_in = {Bit_in, shift_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    complete  = 1'b0;
    word      = shift_in;
`ifdef PARITY_CHECK_EN
    perr_d    = perr_q;
    word_perr = 1'b0;
`endif

    unique case (state_q)
      StCollect: begin
        if (Bit_valid) begin
          shift_d = shift_in;
          if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef PARITY_CHECK_EN
            // Count holds at WIDTH while waiting for the parity bit.
            state_d = StParity;
            cnt_d   = CW'(WIDTH);
`else
            complete = 1'b1;
            cnt_d    = '0;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
`ifdef PARITY_CHECK_EN
      StParity: begin
        if (Bit_valid) begin
          complete  = 1'b1;
          word      = shift_q;
          word_perr = (^shift_q) ^ Bit_in;
          state_d   = StCollect;
          cnt_d     = '0;
        end
      end
`endif
      default: state_d = StCollect;
    endcase

    // A finished word may only land if the output slot is free or being drained this edge.
    if (complete) begin
      if (!valid_q || Ready) begin
        data_d  = word;
        valid_d = 1'b1;
`ifdef PARITY_CHECK_EN
        perr_d  = word_perr;
`endif
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && Ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= StCollect;
      shift_q   <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
`ifdef PARITY_CHECK_EN
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
`ifdef PARITY_CHECK_EN
      perr_q    <= perr_d;
`endif
    end
  end

  assign Data_out  = data_q;
  assign Valid_out = valid_q;
  assign Bit_count = cnt_q;
  assign Overrun   = overrun_q;
`ifdef PARITY_CHECK_EN
  assign Parity_err = perr_q;
`else
  assign Parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Directed bench: an MSB-first and an LSB-first deserializer driven by the same bit stream.
module tb_serial_word_deserializer;

  logic       Clock = 1'b0;
  logic       Reset, Bit_in, Bit_valid, Ready;
  logic [7:0] data_m, data_l;
  logic       valid_m, valid_l, ovr_m, ovr_l, perr_m, perr_l;
  logic [3:0] cnt_m, cnt_l;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clock = ~Clock;

  serial_word_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .Clock(Clock), .Reset(Reset), .Bit_in(Bit_in), .Bit_valid(Bit_valid), .Ready(Ready),
    .Data_out(data_m), .Valid_out(valid_m), .Bit_count(cnt_m), .Overrun(ovr_m),
    .Parity_err(perr_m)
  );

  serial_word_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .Clock(Clock), .Reset(Reset), .Bit_in(Bit_in), .Bit_valid(Bit_valid), .Ready(Ready),
    .Data_out(data_l), .Valid_out(valid_l), .Bit_count(cnt_l), .Overrun(ovr_l),
    .Parity_err(perr_l)
  );

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic send_bit(input logic b);
    Bit_in    = b;
    Bit_valid = 1'b1;
    tick();
    Bit_valid = 1'b0;
  endtask

  // Sends w MSB first; with parity enabled a parity bit (even, optionally flipped) follows.
  task automatic send_word(input logic [7:0] w, input logic flip, input logic ready_last,
                           input logic gap);
    for (int i = 0; i < 8; i++) begin
`ifndef PARITY_CHECK_EN
      if (i == 7 && ready_last) Ready = 1'b1;
`endif
      send_bit(w[7-i]);
      Ready = 1'b0;
      if (gap) tick();
    end
`ifdef PARITY_CHECK_EN
    if (ready_last) Ready = 1'b1;
    send_bit((^w) ^ flip);
    Ready = 1'b0;
    if (gap) tick();
`else
    if (flip) tick();
`endif
  endtask

  task automatic drain();
    Ready = 1'b1;
    tick();
    Ready = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Bit_valid = 1'b1; Bit_in = 1'b1; Ready = 1'b0;
    tick(); tick();
    Reset = 1'b0; Bit_valid = 1'b0;
    n_checks++;
    if ({data_m, valid_m, cnt_m, ovr_m, perr_m} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got data=%h valid=%b cnt=%0d ovr=%b perr=%b, want all 0",
               data_m, valid_m, cnt_m, ovr_m, perr_m);
    end
  endtask

  task automatic test_basic();
    logic [7:0] w;
    w = 8'hB2;
    for (int i = 0; i < 7; i++) send_bit(w[7-i]);
    n_checks++;
    if (cnt_m !== 4'd7 || valid_m !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_count7: got cnt=%0d valid=%b, want cnt=7 valid=0", cnt_m, valid_m);
    end
    send_bit(w[0]);
`ifdef PARITY_CHECK_EN
    n_checks++;
    if (cnt_m !== 4'd8 || valid_m !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_await_parity: got cnt=%0d valid=%b, want 8/0", cnt_m, valid_m);
    end
    send_bit(1'b0);
`endif
    n_checks++;
    if (data_m !== 8'hB2 || valid_m !== 1'b1 || cnt_m !== 4'd0) begin
      n_fail++;
      $display("FAIL basic_word: got data=%h valid=%b cnt=%0d, want b2/1/0",
               data_m, valid_m, cnt_m);
    end
    n_checks++;
    if (data_l !== 8'h4D) begin
      n_fail++;
      $display("FAIL basic_lsb_word: got %h want 4d", data_l);
    end
    repeat (3) tick();
    n_checks++;
    if (data_m !== 8'hB2 || valid_m !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_hold: got data=%h valid=%b, want b2/1", data_m, valid_m);
    end
    drain();
    n_checks++;
    if (valid_m !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_accept: got valid=%b want 0", valid_m);
    end
  endtask

  task automatic test_gaps();
    send_word(8'hB2, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (data_m !== 8'hB2 || valid_m !== 1'b1 || data_l !== 8'h4D || valid_l !== 1'b1) begin
      n_fail++;
      $display("FAIL gaps_word: got msb=%h/%b lsb=%h/%b, want b2/1 4d/1",
               data_m, valid_m, data_l, valid_l);
    end
    drain();
  endtask

  task automatic test_overrun();
    send_word(8'hB2, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (data_m !== 8'hB2 || valid_m !== 1'b1 || ovr_m !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_first: got data=%h valid=%b ovr=%b, want b2/1/0",
               data_m, valid_m, ovr_m);
    end
    send_word(8'hFF, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (data_m !== 8'hB2 || valid_m !== 1'b1 || ovr_m !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_dropped: got data=%h valid=%b ovr=%b, want b2/1/1",
               data_m, valid_m, ovr_m);
    end
    send_word(8'hFF, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (data_m !== 8'hFF || valid_m !== 1'b1 || ovr_m !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_replace: got data=%h valid=%b ovr=%b, want ff/1/1",
               data_m, valid_m, ovr_m);
    end
  endtask

  task automatic test_midframe_reset();
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    n_checks++;
    if (cnt_m !== 4'd0 || valid_m !== 1'b0 || ovr_m !== 1'b0 || data_m !== 8'h00) begin
      n_fail++;
      $display("FAIL midreset_clear: got cnt=%0d valid=%b ovr=%b data=%h, want 0/0/0/00",
               cnt_m, valid_m, ovr_m, data_m);
    end
    send_word(8'h0F, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (data_m !== 8'h0F || valid_m !== 1'b1 || data_l !== 8'hF0) begin
      n_fail++;
      $display("FAIL midreset_word: got msb=%h valid=%b lsb=%h, want 0f/1/f0",
               data_m, valid_m, data_l);
    end
    drain();
  endtask

  task automatic test_parity();
`ifdef PARITY_CHECK_EN
    send_word(8'hB2, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (data_m !== 8'hB2 || valid_m !== 1'b1 || perr_m !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_good: got data=%h valid=%b perr=%b, want b2/1/0",
               data_m, valid_m, perr_m);
    end
    drain();
    send_word(8'hB2, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (data_m !== 8'hB2 || valid_m !== 1'b1 || perr_m !== 1'b1) begin
      n_fail++;
      $display("FAIL parity_bad: got data=%h valid=%b perr=%b, want b2/1/1",
               data_m, valid_m, perr_m);
    end
    drain();
`else
    send_word(8'h01, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (data_m !== 8'h01 || valid_m !== 1'b1 || perr_m !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_tied: got data=%h valid=%b perr=%b, want 01/1/0",
               data_m, valid_m, perr_m);
    end
    drain();
`endif
  endtask

  initial begin
    Reset = 1'b1; Bit_in = 1'b0; Bit_valid = 1'b0; Ready = 1'b0;
    test_reset();
    test_basic();
    test_gaps();
    test_overrun();
    test_midframe_reset();
    test_parity();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
